// File: rtl/hazard_stall_ctrl_if.sv
// Hazard/stall controller bundle: ID/EX/MEM hazard inputs and pipeline control outputs.
// HAZARD_PERF_CNT_EN adds the stall/freeze performance counter outputs.
interface hazard_stall_ctrl_if;
    logic [4:0]  ID_Rs1_i;
    logic [4:0]  ID_Rs2_i;
    logic        EX_MemRead_i;
    logic [4:0]  EX_Rd_i;
    logic        MEM_MemAccess_i;
    logic        Mem_Ack_i;
    logic        Branch_i;
    logic        PC_Write_o;
    logic        IF_ID_Write_o;
    logic        NoOp_o;
    logic        Freeze_o;
    logic        Flush_o;
    logic        Mem_Req_o;
    logic        Mem_Err_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] Stall_Cnt_o;
    logic [31:0] Freeze_Cnt_o;
`endif

    modport slave (
        input  ID_Rs1_i, ID_Rs2_i, EX_MemRead_i, EX_Rd_i, MEM_MemAccess_i, Mem_Ack_i, Branch_i,
        output PC_Write_o, IF_ID_Write_o, NoOp_o, Freeze_o, Flush_o, Mem_Req_o, Mem_Err_o
`ifdef HAZARD_PERF_CNT_EN
        , output Stall_Cnt_o, Freeze_Cnt_o
`endif
    );

    modport master (
        output ID_Rs1_i, ID_Rs2_i, EX_MemRead_i, EX_Rd_i, MEM_MemAccess_i, Mem_Ack_i, Branch_i,
        input  PC_Write_o, IF_ID_Write_o, NoOp_o, Freeze_o, Flush_o, Mem_Req_o, Mem_Err_o
`ifdef HAZARD_PERF_CNT_EN
        , input Stall_Cnt_o, Freeze_Cnt_o
`endif
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use stall, MEM handshake freeze with timeout, and branch flush qualification.
// HAZARD_PERF_CNT_EN adds wrapping stall/freeze cycle counters.
module hazard_stall_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TO_W        = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    hazard_stall_ctrl_if.slave   hz
);
    typedef enum logic [0:0] {StRun, StMemWait} state_e;

    localparam logic [TO_W-1:0] TimeoutVal = TO_W'(MEM_TIMEOUT);
    localparam logic [TO_W-1:0] CountMax   = '1;
    localparam logic [TO_W-1:0] CountOne   = TO_W'(1);

    state_e          state_q, state_d;
    logic [TO_W-1:0] count_q, count_d;
    logic            mem_err_q, mem_err_d;
    logic            frz_raw, frz, load_use, mem_req;

    assign load_use = hz.EX_MemRead_i && (hz.EX_Rd_i != 5'd0) &&
                      ((hz.EX_Rd_i == hz.ID_Rs1_i) || (hz.EX_Rd_i == hz.ID_Rs2_i));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= StRun;
            count_q   <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            mem_err_q <= mem_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        mem_err_d = mem_err_q;
        frz_raw   = 1'b0;
        mem_req   = 1'b0;
        unique case (state_q)
            StRun: begin
                mem_req = hz.MEM_MemAccess_i;
                if (hz.MEM_MemAccess_i && !hz.Mem_Ack_i) begin
                    frz_raw = 1'b1;
                    state_d = StMemWait;
                    count_d = CountOne;
                end
            end
            StMemWait: begin
                if (hz.Mem_Ack_i) begin
                    mem_req = 1'b1;
                    state_d = StRun;
                    count_d = '0;
                end else if (count_q == TimeoutVal) begin
                    // Abort: drop the request and release the pipeline this cycle.
                    mem_err_d = 1'b1;
                    state_d   = StRun;
                    count_d   = '0;
                end else begin
                    mem_req = 1'b1;
                    frz_raw = 1'b1;
                    count_d = (count_q == CountMax) ? count_q : count_q + CountOne;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // Reset overrides the decode so the pipeline runs freely while held in reset.
    assign frz = frz_raw && rst_i;

    always_comb begin
        hz.PC_Write_o    = 1'b1;
        hz.IF_ID_Write_o = 1'b1;
        hz.NoOp_o        = 1'b0;
        hz.Flush_o       = 1'b0;
        if (!rst_i) begin
            hz.Flush_o = 1'b0;
        end else if (frz) begin
            hz.PC_Write_o    = 1'b0;
            hz.IF_ID_Write_o = 1'b0;
        end else if (load_use) begin
            hz.PC_Write_o    = 1'b0;
            hz.IF_ID_Write_o = 1'b0;
            hz.NoOp_o        = 1'b1;
        end else begin
            hz.Flush_o = hz.Branch_i;
        end
    end

    assign hz.Freeze_o  = frz;
    assign hz.Mem_Req_o = mem_req;
    assign hz.Mem_Err_o = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, freeze_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            if (hz.NoOp_o) stall_cnt_q  <= stall_cnt_q + 32'd1;
            if (frz)       freeze_cnt_q <= freeze_cnt_q + 32'd1;
        end
    end

    assign hz.Stall_Cnt_o  = stall_cnt_q;
    assign hz.Freeze_Cnt_o = freeze_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the hazard rules.
module tb_hazard_stall_ctrl;
    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl_if hz ();

    hazard_stall_ctrl #(.MEM_TIMEOUT(TIMEOUT), .TO_W(5)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .hz    (hz)
    );

    // Observed vector: {PC_Write, IF_ID_Write, NoOp, Freeze, Flush, Mem_Req}
    logic [5:0] obs;
    assign obs = {hz.PC_Write_o, hz.IF_ID_Write_o, hz.NoOp_o, hz.Freeze_o, hz.Flush_o,
                  hz.Mem_Req_o};

    // Behavioural model: an access is outstanding for some number of waited cycles.
    logic        m_pending;
    int          m_waited;
    logic        m_err;
    logic        m_active, m_timeout, e_lu, e_frz, e_stall, e_req, e_flush;
    logic [5:0]  exp_obs;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] m_stall_cnt, m_frz_cnt;
`endif

    always_comb begin
        m_active  = m_pending || hz.MEM_MemAccess_i;
        m_timeout = m_pending && !hz.Mem_Ack_i && (m_waited == TIMEOUT);
        e_lu      = hz.EX_MemRead_i && (hz.EX_Rd_i != 0) &&
                    (hz.EX_Rd_i == hz.ID_Rs1_i || hz.EX_Rd_i == hz.ID_Rs2_i);
        e_frz     = rst_n && m_active && !hz.Mem_Ack_i && (m_waited < TIMEOUT);
        e_stall   = rst_n && !e_frz && e_lu;
        e_flush   = rst_n && !e_frz && !e_lu && hz.Branch_i;
        e_req     = m_pending ? !m_timeout : hz.MEM_MemAccess_i;
        exp_obs   = {!(e_frz || e_stall), !(e_frz || e_stall), e_stall, e_frz, e_flush, e_req};
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pending <= 1'b0;
            m_waited  <= 0;
            m_err     <= 1'b0;
`ifdef HAZARD_PERF_CNT_EN
            m_stall_cnt <= '0;
            m_frz_cnt   <= '0;
`endif
        end else begin
            if (m_timeout) begin
                m_pending <= 1'b0;
                m_waited  <= 0;
                m_err     <= 1'b1;
            end else if (hz.Mem_Ack_i) begin
                m_pending <= 1'b0;
                m_waited  <= 0;
            end else if (m_active) begin
                m_pending <= 1'b1;
                m_waited  <= m_waited + 1;
            end
`ifdef HAZARD_PERF_CNT_EN
            if (e_stall) m_stall_cnt <= m_stall_cnt + 32'd1;
            if (e_frz)   m_frz_cnt   <= m_frz_cnt + 32'd1;
`endif
        end
    end

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic memread, input logic access, input logic ack,
                          input logic branch);
        hz.ID_Rs1_i        = rs1;
        hz.ID_Rs2_i        = rs2;
        hz.EX_Rd_i         = rd;
        hz.EX_MemRead_i    = memread;
        hz.MEM_MemAccess_i = access;
        hz.Mem_Ack_i       = ack;
        hz.Branch_i        = branch;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (obs !== 6'b110000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected %b", obs, 6'b110000);
        end
        n_checks++;
        if (hz.Mem_Err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mem_err: got %b expected 0", hz.Mem_Err_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        apply_reset();
        @(negedge clk);
        set_in(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (obs !== 6'b001000) begin
            n_fail++;
            $display("FAIL load_use_stall: got %b expected %b", obs, 6'b001000);
        end
        @(negedge clk);
        set_in(5'd1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (obs !== 6'b110000) begin
            n_fail++;
            $display("FAIL load_use_release: got %b expected %b", obs, 6'b110000);
        end
    endtask

    task automatic test_x0();
        apply_reset();
        @(negedge clk);
        set_in(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (obs !== 6'b110000) begin
            n_fail++;
            $display("FAIL x0_no_stall: got %b expected %b", obs, 6'b110000);
        end
    endtask

    task automatic test_mem_ack();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
            #1;
            n_checks++;
            if (obs !== 6'b000101) begin
                n_fail++;
                $display("FAIL mem_wait_freeze[%0d]: got %b expected %b", i, obs, 6'b000101);
            end
        end
        @(negedge clk);
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (obs !== 6'b110001) begin
            n_fail++;
            $display("FAIL mem_ack_cycle: got %b expected %b", obs, 6'b110001);
        end
        @(negedge clk);
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (obs !== 6'b110000) begin
            n_fail++;
            $display("FAIL mem_back_to_run: got %b expected %b", obs, 6'b110000);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
            #1;
            n_checks++;
            if (obs !== 6'b000101) begin
                n_fail++;
                $display("FAIL timeout_freeze[%0d]: got %b expected %b", i, obs, 6'b000101);
            end
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({obs, hz.Mem_Err_o} !== 7'b1100000) begin
            n_fail++;
            $display("FAIL timeout_abort_cycle: got %b expected %b", {obs, hz.Mem_Err_o},
                     7'b1100000);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            #1;
            n_checks++;
            if (hz.Mem_Err_o !== 1'b1) begin
                n_fail++;
                $display("FAIL timeout_err_sticky[%0d]: got %b expected 1", i, hz.Mem_Err_o);
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (hz.Mem_Err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_err_cleared: got %b expected 0", hz.Mem_Err_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_branch_priority();
        apply_reset();
        @(negedge clk);
        set_in(5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (obs !== 6'b001000) begin
            n_fail++;
            $display("FAIL branch_under_stall: got %b expected %b", obs, 6'b001000);
        end
        @(negedge clk);
        set_in(5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (obs !== 6'b110010) begin
            n_fail++;
            $display("FAIL branch_flush: got %b expected %b", obs, 6'b110010);
        end
        @(negedge clk);
        set_in(5'd3, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (obs !== 6'b000101) begin
            n_fail++;
            $display("FAIL freeze_dominates: got %b expected %b", obs, 6'b000101);
        end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 6'b110001) begin
            n_fail++;
            $display("FAIL reset_mid_wait: got %b expected %b", obs, 6'b110001);
        end
        @(negedge clk);
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (obs !== 6'b110000) begin
            n_fail++;
            $display("FAIL reset_req_follows: got %b expected %b", obs, 6'b110000);
        end
`ifdef HAZARD_PERF_CNT_EN
        n_checks++;
        if ({hz.Stall_Cnt_o, hz.Freeze_Cnt_o} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got %0d/%0d expected 0/0", hz.Stall_Cnt_o,
                     hz.Freeze_Cnt_o);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk);
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (obs !== 6'b110000) begin
            n_fail++;
            $display("FAIL after_reset_wait: got %b expected %b", obs, 6'b110000);
        end
`ifdef HAZARD_PERF_CNT_EN
        n_checks++;
        if (hz.Freeze_Cnt_o !== 32'd3 || hz.Stall_Cnt_o !== 32'd0) begin
            n_fail++;
            $display("FAIL freeze_count: got %0d/%0d expected 3/0", hz.Freeze_Cnt_o,
                     hz.Stall_Cnt_o);
        end
`endif
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 49) != 0);
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3),
                   1'($urandom_range(0, 1)));
            #1;
            n_checks++;
            if ({obs, hz.Mem_Err_o} !== {exp_obs, m_err}) begin
                n_fail++;
                $display("FAIL random[%0d]: got %b expected %b", i, {obs, hz.Mem_Err_o},
                         {exp_obs, m_err});
            end
`ifdef HAZARD_PERF_CNT_EN
            n_checks++;
            if (hz.Stall_Cnt_o !== m_stall_cnt || hz.Freeze_Cnt_o !== m_frz_cnt) begin
                n_fail++;
                $display("FAIL random_counters[%0d]: got %0d/%0d expected %0d/%0d", i,
                         hz.Stall_Cnt_o, hz.Freeze_Cnt_o, m_stall_cnt, m_frz_cnt);
            end
`endif
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_load_use();
        test_x0();
        test_mem_ack();
        test_timeout();
        test_branch_priority();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
